// File: rtl/branch_pkg.sv
// Shared constants and queue entry layout for the branch resolve unit.
package branch_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned INSTR_BYTES   = 4;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// In-order prediction queue: pointers carry a wrap bit so full and empty are distinguishable.
module bru_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  bru_entry_t wdata_i,
  output bru_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  bru_entry_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Clear wins over push/pop: a squash empties the queue in one edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions in X: predictor update strobes, flush/redirect, statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_push,
  input  logic [PC_W-1:0]  d_pc,
  input  logic             d_pred_taken,
  output logic             q_full,
  input  logic             x_valid,
  input  logic [PC_W-1:0]  x_pc,
  input  logic             x_taken,
  input  logic [PC_W-1:0]  x_target,
  output logic             Xbranch,
  output logic [PC_W-1:0]  XPCidx,
  output logic             predictedTaken,
  output logic             predictedWrong,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] n_branches,
  output logic [CNT_W-1:0] n_mispredicts,
  output logic             desync,
  output logic             overflow
);

  bru_entry_t head;
  bru_entry_t wentry;
  logic       full, empty;
  logic       hit, wrong, pop, push;

  logic [CNT_W-1:0] n_br_q, n_br_d;
  logic [CNT_W-1:0] n_mp_q, n_mp_d;
  logic             desync_q, desync_d;
  logic             ovf_q, ovf_d;

  assign wentry = '{pc: d_pc, taken: d_pred_taken};

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (wrong),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign hit   = x_valid && !empty && (head.pc == x_pc);
  assign wrong = hit && (head.taken ^ x_taken);
  assign pop   = hit;
  assign push  = d_push && (!full || pop) && !wrong;

  assign q_full         = full;
  assign Xbranch        = hit;
  assign XPCidx         = x_pc;
  // Empty queue holds stale storage; keep the prediction output quiet then.
  assign predictedTaken = !empty && head.taken;
  assign predictedWrong = wrong;
  assign flush          = wrong;
  assign redirect_pc    = x_taken ? x_target : x_pc + PC_W'(INSTR_BYTES);

  always_comb begin
    n_br_d   = n_br_q;
    n_mp_d   = n_mp_q;
    desync_d = desync_q;
    ovf_d    = ovf_q;
    if (hit && (n_br_q != '1))   n_br_d = n_br_q + 1'b1;
    if (wrong && (n_mp_q != '1)) n_mp_d = n_mp_q + 1'b1;
    if (x_valid && !hit)         desync_d = 1'b1;
    if (d_push && full && !pop)  ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_br_q   <= '0;
      n_mp_q   <= '0;
      desync_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      n_br_q   <= n_br_d;
      n_mp_q   <= n_mp_d;
      desync_q <= desync_d;
      ovf_q    <= ovf_d;
    end
  end

  assign n_branches    = n_br_q;
  assign n_mispredicts = n_mp_q;
  assign desync        = desync_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue-based reference model checked every cycle.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             d_push;
  logic [31:0]      d_pc;
  logic             d_pred_taken;
  logic             q_full;
  logic             x_valid;
  logic [31:0]      x_pc;
  logic             x_taken;
  logic [31:0]      x_target;
  logic             Xbranch;
  logic [31:0]      XPCidx;
  logic             predictedTaken;
  logic             predictedWrong;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] n_branches;
  logic [CNT_W-1:0] n_mispredicts;
  logic             desync;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .d_push         (d_push),
    .d_pc           (d_pc),
    .d_pred_taken   (d_pred_taken),
    .q_full         (q_full),
    .x_valid        (x_valid),
    .x_pc           (x_pc),
    .x_taken        (x_taken),
    .x_target       (x_target),
    .Xbranch        (Xbranch),
    .XPCidx         (XPCidx),
    .predictedTaken (predictedTaken),
    .predictedWrong (predictedWrong),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .n_branches     (n_branches),
    .n_mispredicts  (n_mispredicts),
    .desync         (desync),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of outstanding predictions plus scalar statistics.
  typedef struct {
    logic [31:0] pc;
    bit          taken;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_br = 0;
  int unsigned m_mp = 0;
  bit          m_desync = 0;
  bit          m_ovf = 0;

  function automatic bit m_hit();
    return x_valid && (mq.size() > 0) && (mq[0].pc == x_pc);
  endfunction

  function automatic bit m_wrong();
    return m_hit() && (mq[0].taken != x_taken);
  endfunction

  always @(negedge reset) begin
    mq.delete();
    m_br = 0;
    m_mp = 0;
    m_desync = 0;
    m_ovf = 0;
  end

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      bit h, w;
      h = m_hit();
      w = m_wrong();
      if (x_valid && !h) m_desync = 1;
      if (h && m_br < CMAX) m_br++;
      if (w && m_mp < CMAX) m_mp++;
      if (w) begin
        mq.delete();
      end else begin
        if (d_push && mq.size() == DEPTH && !h) m_ovf = 1;
        if (h) void'(mq.pop_front());
        if (d_push && mq.size() < DEPTH) mq.push_back('{pc: d_pc, taken: d_pred_taken});
      end
    end
  end

  always @(negedge clock) begin
    bit h, w;
    h = m_hit();
    w = m_wrong();
    chk("q_full",         {31'd0, q_full},         {31'd0, mq.size() == DEPTH});
    chk("Xbranch",        {31'd0, Xbranch},        {31'd0, h});
    chk("XPCidx",         XPCidx,                  x_pc);
    chk("predictedTaken", {31'd0, predictedTaken}, {31'd0, (mq.size() > 0) && mq[0].taken});
    chk("predictedWrong", {31'd0, predictedWrong}, {31'd0, w});
    chk("flush",          {31'd0, flush},          {31'd0, w});
    chk("redirect_pc",    redirect_pc,             x_taken ? x_target : x_pc + 32'd4);
    chk("n_branches",     32'(n_branches),         m_br);
    chk("n_mispredicts",  32'(n_mispredicts),      m_mp);
    chk("desync",         {31'd0, desync},         {31'd0, m_desync});
    chk("overflow",       {31'd0, overflow},       {31'd0, m_ovf});
  end

  task automatic cyc(input bit push, input logic [31:0] pc, input bit pt,
                     input bit xv, input logic [31:0] xpc, input bit xt,
                     input logic [31:0] xtgt);
    @(posedge clock);
    #1;
    d_push = push; d_pc = pc; d_pred_taken = pt;
    x_valid = xv; x_pc = xpc; x_taken = xt; x_target = xtgt;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    d_push = 0; d_pc = '0; d_pred_taken = 0;
    x_valid = 0; x_pc = '0; x_taken = 0; x_target = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    idle();
    chk("rst_nbr", 32'(n_branches), 32'd0);
    chk("rst_full", {31'd0, q_full}, 32'd0);

    // Correct prediction
    cyc(1, 32'h40, 1, 0, 32'h0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 32'h40, 1, 32'h200);
    chk("t2_xbranch", {31'd0, Xbranch}, 32'd1);
    chk("t2_wrong", {31'd0, predictedWrong}, 32'd0);
    chk("t2_flush", {31'd0, flush}, 32'd0);
    idle();
    chk("t2_nbr", 32'(n_branches), 32'd1);
    chk("t2_nmp", 32'(n_mispredicts), 32'd0);

    // Mispredict, actually not taken
    cyc(1, 32'h40, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 32'h44, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 32'h40, 0, 32'h300);
    chk("t3_flush", {31'd0, flush}, 32'd1);
    chk("t3_redir", redirect_pc, 32'h44);
    idle();
    chk("t3_full", {31'd0, q_full}, 32'd0);
    chk("t3_nmp", 32'(n_mispredicts), 32'd1);

    // Mispredict, actually taken
    cyc(1, 32'h80, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 32'h80, 1, 32'h100);
    chk("t4_flush", {31'd0, flush}, 32'd1);
    chk("t4_redir", redirect_pc, 32'h100);
    idle();

    // Fill, overflow, then full with simultaneous pop and push
    for (int i = 0; i < 4; i++) cyc(1, 32'h10 + 32'(4 * i), 1, 0, 32'h0, 0, 32'h0);
    idle();
    chk("t5_full", {31'd0, q_full}, 32'd1);
    cyc(1, 32'h20, 1, 0, 32'h0, 0, 32'h0);
    idle();
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    cyc(1, 32'h24, 1, 1, 32'h10, 1, 32'h500);
    chk("t5_popx", {31'd0, Xbranch}, 32'd1);
    idle();
    chk("t5_full2", {31'd0, q_full}, 32'd1);
    cyc(0, 32'h0, 0, 1, 32'h14, 1, 32'h500);
    cyc(0, 32'h0, 0, 1, 32'h18, 1, 32'h500);
    cyc(0, 32'h0, 0, 1, 32'h1c, 1, 32'h500);
    cyc(0, 32'h0, 0, 1, 32'h24, 1, 32'h500);
    chk("t5_lastx", {31'd0, Xbranch}, 32'd1);
    idle();
    chk("t5_nbr", 32'(n_branches), 32'd8);

    // Desync: empty queue, then PC mismatch without pop
    cyc(0, 32'h0, 0, 1, 32'h40, 1, 32'h0);
    chk("t6_xb_empty", {31'd0, Xbranch}, 32'd0);
    idle();
    chk("t6_desync", {31'd0, desync}, 32'd1);
    cyc(1, 32'h40, 1, 0, 32'h0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 32'h48, 1, 32'h0);
    chk("t6_xb_mis", {31'd0, Xbranch}, 32'd0);
    cyc(0, 32'h0, 0, 1, 32'h40, 1, 32'h0);
    chk("t6_nopop", {31'd0, Xbranch}, 32'd1);
    idle();

    // Saturation of both counters
    for (int i = 0; i < 8; i++) begin
      cyc(1, 32'h300 + 32'(4 * i), 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 32'h0, 0, 1, 32'h300 + 32'(4 * i), 0, 32'h0);
    end
    for (int i = 0; i < 14; i++) begin
      cyc(1, 32'h400 + 32'(4 * i), 1, 0, 32'h0, 0, 32'h0);
      cyc(0, 32'h0, 0, 1, 32'h400 + 32'(4 * i), 0, 32'h0);
    end
    idle();
    chk("sat_nbr", 32'(n_branches), 32'd15);
    chk("sat_nmp", 32'(n_mispredicts), 32'd15);

    // Asynchronous reset mid-operation
    cyc(1, 32'h200, 1, 0, 32'h0, 0, 32'h0);
    @(posedge clock);
    #1;
    d_push = 0; x_valid = 1; x_pc = 32'h200; x_taken = 1; x_target = 32'h0;
    #1 chk("t1_pre_xb", {31'd0, Xbranch}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t1_xb", {31'd0, Xbranch}, 32'd0);
    chk("t1_full", {31'd0, q_full}, 32'd0);
    chk("t1_nbr", 32'(n_branches), 32'd0);
    chk("t1_nmp", 32'(n_mispredicts), 32'd0);
    chk("t1_desync", {31'd0, desync}, 32'd0);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    x_valid = 0;
    @(negedge clock);
    idle();
    chk("post_nbr", 32'(n_branches), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
